// File: rtl/switch_pkg.sv
// Shared types, default parameters and width helpers for the break-before-make switch controller.
package switch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam int unsigned DEF_N_SW     = 4;
    localparam int unsigned DEF_DEAD_CYC = 2;
    localparam int unsigned DEF_MIN_HOLD = 4;
    localparam int unsigned DEF_MAX_HOLD = 16;

    // Index width, kept at least one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must hold the value n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/switch_bbm_ctrl_rr_pick.sv
// Combinational round-robin selector: first set req bit at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N_SW  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_SW-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < N_SW; i++) begin
            cand = IDX_W'((32'(ptr) + i) % N_SW);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/switch_bbm_ctrl.sv
// Break-before-make round-robin enable generator for N tristate cells on one shared net.
// Optional contention checker on err: define SWITCH_BBM_CTRL_CONTENTION_CHK_EN.
module switch_bbm_ctrl
    import switch_pkg::*;
#(
    parameter  int unsigned N_SW     = DEF_N_SW,
    parameter  int unsigned DEAD_CYC = DEF_DEAD_CYC,
    parameter  int unsigned MIN_HOLD = DEF_MIN_HOLD,
    parameter  int unsigned MAX_HOLD = DEF_MAX_HOLD,
    localparam int unsigned IDX_W    = idx_w(N_SW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SW-1:0]  req,
    output logic [N_SW-1:0]  ctrl,
    output logic [IDX_W-1:0] owner,
    output logic             busy,
    output logic             err
);

    localparam int unsigned HOLD_SAT = (MAX_HOLD > MIN_HOLD) ? MAX_HOLD : MIN_HOLD;
    localparam int unsigned MAX_CMP  = (MAX_HOLD == 0) ? HOLD_SAT : MAX_HOLD;
    localparam bit          MAX_EN   = (MAX_HOLD != 0);
    localparam int unsigned HOLD_W   = cnt_w(HOLD_SAT);
    localparam int unsigned DEAD_W   = cnt_w(DEAD_CYC);

    state_t            state, state_nx;
    logic [IDX_W-1:0]  ptr, ptr_nx, owner_nx;
    logic [N_SW-1:0]   ctrl_nx, owner_mask, pick_mask;
    logic [HOLD_W-1:0] hold_cnt, hold_nx;
    logic [DEAD_W-1:0] dead_cnt, dead_nx;
    logic              pick_valid, rel;
    logic [IDX_W-1:0]  pick_idx;

    rr_pick #(
        .N_SW  (N_SW),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Release only after the minimum hold; forced hand-over needs another requester waiting.
    always_comb begin
        owner_mask        = '0;
        owner_mask[owner] = 1'b1;
        pick_mask           = '0;
        pick_mask[pick_idx] = 1'b1;
        rel = (hold_cnt >= HOLD_W'(MIN_HOLD)) &&
              (!req[owner] ||
               (MAX_EN && (hold_cnt >= HOLD_W'(MAX_CMP)) && (|(req & ~owner_mask))));
    end

    always_comb begin
        state_nx = state;
        ctrl_nx  = ctrl;
        owner_nx = owner;
        ptr_nx   = ptr;
        hold_nx  = hold_cnt;
        dead_nx  = dead_cnt;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nx = ON;
                    owner_nx = pick_idx;
                    ctrl_nx  = pick_mask;
                    hold_nx  = HOLD_W'(1);
                end
            end
            ON: begin
                if (rel) begin
                    state_nx = DEAD;
                    ctrl_nx  = '0;
                    ptr_nx   = (owner == IDX_W'(N_SW - 1)) ? '0 : owner + IDX_W'(1);
                    hold_nx  = '0;
                    dead_nx  = DEAD_W'(1);
                end else if (hold_cnt < HOLD_W'(HOLD_SAT)) begin
                    hold_nx = hold_cnt + HOLD_W'(1);
                end
            end
            DEAD: begin
                if (dead_cnt >= DEAD_W'(DEAD_CYC)) begin
                    dead_nx = '0;
                    if (pick_valid) begin
                        state_nx = ON;
                        owner_nx = pick_idx;
                        ctrl_nx  = pick_mask;
                        hold_nx  = HOLD_W'(1);
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    dead_nx = dead_cnt + DEAD_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                ctrl_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ctrl     <= '0;
            owner    <= '0;
            ptr      <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            dead_cnt <= '0;
        end else begin
            state    <= state_nx;
            ctrl     <= ctrl_nx;
            owner    <= owner_nx;
            ptr      <= ptr_nx;
            busy     <= (state_nx != IDLE);
            hold_cnt <= hold_nx;
            dead_cnt <= dead_nx;
        end
    end

`ifdef SWITCH_BBM_CTRL_CONTENTION_CHK_EN
    logic [N_SW-1:0]   last_nz;
    logic [DEAD_W-1:0] zero_run;

    // Watches the registered enables: multi-hot, or owner change without a full dead gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_nz  <= '0;
            zero_run <= '0;
            err      <= 1'b0;
        end else begin
            if ((ctrl & (ctrl - N_SW'(1))) != '0) begin
                err <= 1'b1;
            end
            if (ctrl == '0) begin
                if (zero_run < DEAD_W'(DEAD_CYC)) begin
                    zero_run <= zero_run + DEAD_W'(1);
                end
            end else begin
                if ((last_nz != '0) && (ctrl != last_nz) && (zero_run < DEAD_W'(DEAD_CYC))) begin
                    err <= 1'b1;
                end
                last_nz  <= ctrl;
                zero_run <= '0;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_switch_bbm_ctrl.sv
// Directed bench for switch_bbm_ctrl with N_SW=4, DEAD_CYC=2, MIN_HOLD=4, MAX_HOLD=16.
module tb_switch_bbm_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] ctrl;
    logic [1:0] owner;
    logic       busy;
    logic       err;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    switch_bbm_ctrl #(
        .N_SW     (4),
        .DEAD_CYC (2),
        .MIN_HOLD (4),
        .MAX_HOLD (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .ctrl  (ctrl),
        .owner (owner),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            step();
            chk_cnt++;
            if (ctrl !== 4'b0000) $display("FAIL reset_ctrl cyc=%0d got=%b exp=0000", k, ctrl);
            else pass_cnt++;
            chk_cnt++;
            if (busy !== 1'b0) $display("FAIL reset_busy cyc=%0d got=%b exp=0", k, busy);
            else pass_cnt++;
            chk_cnt++;
            if (owner !== 2'd0) $display("FAIL reset_owner cyc=%0d got=%0d exp=0", k, owner);
            else pass_cnt++;
            chk_cnt++;
            if (err !== 1'b0) $display("FAIL reset_err cyc=%0d got=%b exp=0", k, err);
            else pass_cnt++;
        end
        rst = 1'b0;
        req = 4'b0000;
        step();
    endtask

    task automatic test_short_request();
        logic [3:0] exp_ctrl;
        logic       exp_busy;
        req = 4'b0010;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 1) req = 4'b0000;
            exp_ctrl = (k <= 4) ? 4'b0010 : 4'b0000;
            exp_busy = (k <= 6);
            chk_cnt++;
            if (ctrl !== exp_ctrl) $display("FAIL short_ctrl t+%0d got=%b exp=%b", k, ctrl, exp_ctrl);
            else pass_cnt++;
            chk_cnt++;
            if (busy !== exp_busy) $display("FAIL short_busy t+%0d got=%b exp=%b", k, busy, exp_busy);
            else pass_cnt++;
        end
        chk_cnt++;
        if (owner !== 2'd1) $display("FAIL short_owner_hold got=%0d exp=1", owner);
        else pass_cnt++;
    endtask

    task automatic test_two_contenders();
        logic [3:0] exp_ctrl;
        do_reset();
        req = 4'b0101;
        for (int k = 1; k <= 34; k++) begin
            step();
            exp_ctrl = (k <= 16) ? 4'b0001 : (k <= 18) ? 4'b0000 : 4'b0100;
            chk_cnt++;
            if (ctrl !== exp_ctrl) $display("FAIL two_ctrl cyc=%0d got=%b exp=%b", k, ctrl, exp_ctrl);
            else pass_cnt++;
        end
        chk_cnt++;
        if (err !== 1'b0) $display("FAIL two_err got=%b exp=0", err);
        else pass_cnt++;
        req = 4'b0000;
    endtask

    task automatic test_fairness();
        logic [3:0] exp_ctrl;
        int         g;
        int         pos;
        do_reset();
        req = 4'b1111;
        for (int k = 1; k <= 88; k++) begin
            step();
            g   = (k - 1) / 18;
            pos = (k - 1) % 18;
            exp_ctrl = (pos < 16) ? 4'(1 << (g % 4)) : 4'b0000;
            chk_cnt++;
            if (ctrl !== exp_ctrl) $display("FAIL fair_ctrl cyc=%0d got=%b exp=%b", k, ctrl, exp_ctrl);
            else pass_cnt++;
            if (pos == 0) begin
                chk_cnt++;
                if (owner !== 2'(g % 4)) $display("FAIL fair_owner cyc=%0d got=%0d exp=%0d", k, owner, g % 4);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (err !== 1'b0) $display("FAIL fair_err got=%b exp=0", err);
        else pass_cnt++;
        req = 4'b0000;
    endtask

    task automatic test_reset_mid_grant();
        // Grant to owner 1, then reset mid-grant.
        do_reset();
        req = 4'b0010;
        step();
        step();
        chk_cnt++;
        if (ctrl !== 4'b0010) $display("FAIL mid_pre_ctrl got=%b exp=0010", ctrl);
        else pass_cnt++;
        rst = 1'b1;
        req = 4'b0110;
        step();
        chk_cnt++;
        if (ctrl !== 4'b0000) $display("FAIL mid_rst_ctrl got=%b exp=0000", ctrl);
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL mid_rst_busy got=%b exp=0", busy);
        else pass_cnt++;
        rst = 1'b0;
        step();
        chk_cnt++;
        if (owner !== 2'd1) $display("FAIL mid_post_owner got=%0d exp=1", owner);
        else pass_cnt++;
        chk_cnt++;
        if (ctrl !== 4'b0010) $display("FAIL mid_post_ctrl got=%b exp=0010", ctrl);
        else pass_cnt++;

        // Reset while owner 2 holds (ptr=2): ptr must return to 0 so owner 1 wins next.
        do_reset();
        req = 4'b1111;
        for (int k = 1; k <= 38; k++) step();
        chk_cnt++;
        if (ctrl !== 4'b0100) $display("FAIL mid2_pre_ctrl got=%b exp=0100", ctrl);
        else pass_cnt++;
        rst = 1'b1;
        req = 4'b0110;
        step();
        chk_cnt++;
        if (ctrl !== 4'b0000) $display("FAIL mid2_rst_ctrl got=%b exp=0000", ctrl);
        else pass_cnt++;
        rst = 1'b0;
        step();
        chk_cnt++;
        if (owner !== 2'd1) $display("FAIL mid2_post_owner got=%0d exp=1", owner);
        else pass_cnt++;
        chk_cnt++;
        if (ctrl !== 4'b0010) $display("FAIL mid2_post_ctrl got=%b exp=0010", ctrl);
        else pass_cnt++;
        req = 4'b0000;
    endtask

    task automatic test_sole_requester();
        // No contender: no forced release past MAX_HOLD; then the same owner re-wins after a gap.
        do_reset();
        req = 4'b0001;
        for (int k = 1; k <= 20; k++) step();
        chk_cnt++;
        if (ctrl !== 4'b0001) $display("FAIL sole_hold_ctrl got=%b exp=0001", ctrl);
        else pass_cnt++;
        req = 4'b0000;
        step();
        chk_cnt++;
        if (ctrl !== 4'b0000) $display("FAIL sole_rel_ctrl got=%b exp=0000", ctrl);
        else pass_cnt++;
        req = 4'b0001;
        step();
        step();
        chk_cnt++;
        if (ctrl !== 4'b0001) $display("FAIL sole_rewin_ctrl got=%b exp=0001", ctrl);
        else pass_cnt++;
        chk_cnt++;
        if (err !== 1'b0) $display("FAIL sole_err got=%b exp=0", err);
        else pass_cnt++;
        req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_short_request();
        test_two_contenders();
        test_fairness();
        test_reset_mid_grant();
        test_sole_requester();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/switch_bbm_ctrl.md
Name: switch_bbm_ctrl

Overview:
Break-before-make controller that generates the `ctrl` enables for N tristate switch cells sharing one wire. Each cell is an in/ctrl/out switch that drives `in` when ctrl=1 and 'z when ctrl=0. The block sits directly upstream of those cells and arbitrates N requesters round-robin. It guarantees at most one ctrl bit is high at any time, with a programmable all-off dead gap between owners, so the shared net never sees contention.

Parameters:
- N_SW, 4, number of switch cells / requesters (>=2).
- DEAD_CYC, 2, all-off cycles inserted between owners (>=1).
- MIN_HOLD, 4, minimum cycles a granted ctrl stays high (>=1).
- MAX_HOLD, 16, forced release after this many high cycles if another requester is pending; 0 = no limit (>=MIN_HOLD when nonzero).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- req  input  N_SW  per-requester request, level-sensitive
- ctrl  output  N_SW  switch enables, registered, one-hot or zero
- owner  output  IDX_W  index of current/last owner; IDX_W = $clog2(N_SW)
- busy  output  1  high in any state other than IDLE
- err  output  1  sticky contention flag (see Optional Feature)

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: ctrl=0, owner=0, busy=0, err=0, state=IDLE, rr pointer ptr=0, hold/dead counters=0.
- rst asserted mid-operation: ctrl=0 at the next edge. No dead gap is enforced after reset.
- States: IDLE, ON, DEAD. All outputs are registered.
- Arbitration (pick): among req bits, select the first set index at or after ptr, wrapping modulo N_SW.
- IDLE:
  - If any req is set, go to ON. Set ctrl[pick]=1 and owner=pick at the next edge (latency 1 cycle from req sampled).
  - Otherwise stay in IDLE.
- ON:
  - ctrl = one-hot(owner).
  - hold_cnt counts cycles with ctrl high, saturating at max(MIN_HOLD, MAX_HOLD).
  - Release condition at hold_cnt>=MIN_HOLD is either of:
    - req[owner]==0, or
    - MAX_HOLD!=0, hold_cnt>=MAX_HOLD, and another req bit is set.
  - On release: ctrl=0 next edge, ptr=(owner+1) mod N_SW, go to DEAD.
  - req[owner] dropping before MIN_HOLD does not shorten the grant.
- DEAD:
  - ctrl=0 for exactly DEAD_CYC cycles.
  - On the last dead cycle, evaluate pick. If any req is set, go to ON with the new owner, so the gap is exactly DEAD_CYC zero cycles. Otherwise go to IDLE.
- The previous owner may win again only if it is the sole requester (ptr has moved past it).
- owner holds its last value through DEAD and IDLE.
- Invariant: ctrl is never non-zero on two consecutive cycles with different bits set.

Optional Feature:
- Macro: SWITCH_BBM_CTRL_CONTENTION_CHK_EN.
- Defined:
  - An internal checker sets err=1 (sticky until rst) if ctrl is not one-hot-or-zero.
  - It also sets err=1 if ctrl switches from one non-zero value to a different non-zero value with fewer than DEAD_CYC zero cycles between them.
- Undefined: err is tied 0 and no checker logic is synthesized.

Decomposition:
- Package switch_pkg:
  - state_t enum {IDLE, ON, DEAD}.
  - IDX_W derivation helper (clog2 wrapper).
  - Default parameter constants.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req, ptr.
  - Outputs: valid, idx.
  - Instantiated once in switch_bbm_ctrl.

Test Plan (N_SW=4, DEAD_CYC=2, MIN_HOLD=4, MAX_HOLD=16):
- Reset: hold rst 2 cycles with req=4'b1111 -> ctrl=4'b0000, busy=0, owner=0, err=0 throughout reset.
- Short request: req=4'b0010 for 1 cycle at t -> ctrl=4'b0010 for t+1..t+4; ctrl=0 at t+5..t+6; busy=1 for t+1..t+6, busy=0 at t+7.
- Two contenders: req=4'b0101 held -> ctrl=4'b0001 for 16 cycles, then 2 zero cycles, then ctrl=4'b0100 for 16 cycles; never both bits set.
- Fairness: req=4'b1111 held -> owner sequence 0,1,2,3,0; each grant 16 cycles; each gap 2 cycles.
- Reset mid-grant: rst=1 while ctrl=4'b0010 -> ctrl=4'b0000 next edge, ptr=0. After release of rst with req=4'b0110 -> owner=1.
- Checker (macro defined): run scenarios 3 and 4 -> err stays 0. Build without the macro -> err constant 0.
